// File: rtl/nn_layer_memory.sv
// nn_layer_memory: single-clock layer buffer between matrix-multiply stages.
// The read port is registered and has a valid strobe. A write and a read to the
// same address in one cycle return the write data. Out-of-range accesses raise
// a one-cycle error pulse. A sequential engine zero-fills every word on request.
// Optional feature macro: NN_LAYER_MEMORY_ARGMAX_EN. It adds a running argmax
// tracker over the writes accepted since the last clear.
module nn_layer_memory #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 10,
  parameter int ADDR_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_clear_start,
  output logic                     o_busy,
  input  logic                     i_write_enable,
  input  logic [ADDR_W-1:0]        i_write_addr,
  input  logic signed [DATA_W-1:0] i_data_in,
  input  logic                     i_read_enable,
  input  logic [ADDR_W-1:0]        i_read_addr,
  output logic signed [DATA_W-1:0] o_data_out,
  output logic                     o_read_valid,
  output logic                     o_addr_error
`ifdef NN_LAYER_MEMORY_ARGMAX_EN
  ,
  output logic signed [DATA_W-1:0] o_max_value,
  output logic [ADDR_W-1:0]        o_max_index,
  output logic                     o_max_valid
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // The range check uses one extra bit, so that DEPTH == 2^ADDR_W stays representable.
  localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                     r_state;
  logic [IDX_W-1:0]           r_clr_cnt;
  logic                       r_busy;
  logic signed [DATA_W-1:0]   r_data_out;
  logic                       r_read_valid;
  logic                       r_addr_error;
  logic signed [DATA_W-1:0]   r_mem [DEPTH];

  logic                       w_idle;
  logic                       w_wr_in_range;
  logic                       w_rd_in_range;
  logic                       w_wr_accept;
  logic                       w_wr_err;
  logic                       w_rd_err;
  logic                       w_bypass;
  logic [IDX_W-1:0]           w_wr_idx;
  logic [IDX_W-1:0]           w_rd_idx;
  logic                       w_mem_we;
  logic [IDX_W-1:0]           w_mem_idx;
  logic signed [DATA_W-1:0]   w_mem_data;

  assign w_idle        = (r_state == ST_IDLE);
  assign w_wr_in_range = ({1'b0, i_write_addr} < DEPTH_EXT);
  assign w_rd_in_range = ({1'b0, i_read_addr} < DEPTH_EXT);
  assign w_wr_idx      = i_write_addr[IDX_W-1:0];
  assign w_rd_idx      = i_read_addr[IDX_W-1:0];
  assign w_wr_accept   = w_idle & i_write_enable & w_wr_in_range;
  assign w_wr_err      = w_idle & i_write_enable & ~w_wr_in_range;
  assign w_rd_err      = w_idle & i_read_enable & ~w_rd_in_range;
  assign w_bypass      = w_wr_accept & w_rd_in_range & (i_write_addr == i_read_addr);

  // The clear engine owns the array write port while it runs.
  assign w_mem_we   = w_wr_accept | (r_state == ST_CLEAR);
  assign w_mem_idx  = (r_state == ST_CLEAR) ? r_clr_cnt : w_wr_idx;
  assign w_mem_data = (r_state == ST_CLEAR) ? '0 : i_data_in;

  // Storage array. It has no reset, so contents are undefined until written or cleared.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= w_mem_data;
    end
  end

  // Control FSM: the clear sequencer plus the registered read port and error pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_clr_cnt    <= '0;
      r_busy       <= 1'b0;
      r_data_out   <= '0;
      r_read_valid <= 1'b0;
      r_addr_error <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_read_valid <= i_read_enable;
          r_addr_error <= w_wr_err | w_rd_err;
          if (i_read_enable) begin
            if (!w_rd_in_range) begin
              r_data_out <= '0;
            end else if (w_bypass) begin
              r_data_out <= i_data_in;
            end else begin
              r_data_out <= r_mem[w_rd_idx];
            end
          end
          if (i_clear_start) begin
            r_state   <= ST_CLEAR;
            r_busy    <= 1'b1;
            r_clr_cnt <= '0;
          end
        end
        ST_CLEAR: begin
          r_read_valid <= 1'b0;
          r_addr_error <= 1'b0;
          if (r_clr_cnt == LAST_IDX) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_clr_cnt    <= '0;
          r_read_valid <= 1'b0;
          r_addr_error <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_data_out   = r_data_out;
  assign o_read_valid = r_read_valid;
  assign o_addr_error = r_addr_error;

`ifdef NN_LAYER_MEMORY_ARGMAX_EN
  logic signed [DATA_W-1:0] r_max_value;
  logic [ADDR_W-1:0]        r_max_index;
  logic                     r_max_valid;

  // Running argmax over the accepted writes. A strict compare keeps the earlier entry on ties.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_max_value <= '0;
      r_max_index <= '0;
      r_max_valid <= 1'b0;
    end else if (w_idle && i_clear_start) begin
      r_max_value <= '0;
      r_max_index <= '0;
      r_max_valid <= 1'b0;
    end else if (w_wr_accept && (!r_max_valid || (i_data_in > r_max_value))) begin
      r_max_value <= i_data_in;
      r_max_index <= i_write_addr;
      r_max_valid <= 1'b1;
    end
  end

  assign o_max_value = r_max_value;
  assign o_max_index = r_max_index;
  assign o_max_valid = r_max_valid;
`endif

endmodule

// File: tb/tb_nn_layer_memory.sv
// Testbench for nn_layer_memory with DATA_W=32, DEPTH=10 and ADDR_W=16.
module tb_nn_layer_memory;
  localparam int DW = 32;
  localparam int D  = 10;
  localparam int AW = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cs;
  logic                 busy;
  logic                 we;
  logic [AW-1:0]        wa;
  logic signed [DW-1:0] din;
  logic                 re;
  logic [AW-1:0]        ra;
  logic signed [DW-1:0] dout;
  logic                 rv;
  logic                 err;
`ifdef NN_LAYER_MEMORY_ARGMAX_EN
  logic signed [DW-1:0] max_value;
  logic [AW-1:0]        max_index;
  logic                 max_valid;
`endif

  int total = 0;
  int bad = 0;
  logic [DW-1:0] mdl [D];
  logic [DW-1:0] exp_do;

  always #5 clk = ~clk;

  nn_layer_memory #(.DATA_W(DW), .DEPTH(D), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_reset(reset), .i_clear_start(cs), .o_busy(busy),
    .i_write_enable(we), .i_write_addr(wa), .i_data_in(din),
    .i_read_enable(re), .i_read_addr(ra), .o_data_out(dout),
    .o_read_valid(rv), .o_addr_error(err)
`ifdef NN_LAYER_MEMORY_ARGMAX_EN
    , .o_max_value(max_value), .o_max_index(max_index), .o_max_valid(max_valid)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; re = 1'b0; cs = 1'b0;
    wa = '0; ra = '0; din = '0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < D; i++) begin
      we = 1'b1; wa = AW'(i); din = $urandom | 32'h1;
      mdl[i] = din;
      tick();
    end
    we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (dout !== '0) begin bad++; $display("FAIL reset_dout: got %h want 0", dout); end
    total++; if (rv !== 1'b0) begin bad++; $display("FAIL reset_rv: got %b want 0", rv); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
`ifdef NN_LAYER_MEMORY_ARGMAX_EN
    total++; if (max_valid !== 1'b0) begin bad++; $display("FAIL reset_max_valid: got %b want 0", max_valid); end
`endif
    reset = 1'b0;
    tick();
    exp_do = '0;
  endtask

  task automatic test_basic_rw();
    we = 1'b1; wa = 16'd3; din = -32'sd5;
    mdl[3] = 32'hFFFF_FFFB;
    tick();
    we = 1'b0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL basic_wr_err: got %b want 0", err); end
    re = 1'b1; ra = 16'd3;
    tick();
    re = 1'b0;
    total++; if (rv !== 1'b1) begin bad++; $display("FAIL basic_rv: got %b want 1", rv); end
    total++; if (dout !== 32'hFFFF_FFFB) begin bad++; $display("FAIL basic_dout: got %h want fffffffb", dout); end
    tick();
    total++; if (rv !== 1'b0) begin bad++; $display("FAIL basic_rv_idle: got %b want 0", rv); end
    total++; if (dout !== 32'hFFFF_FFFB) begin bad++; $display("FAIL basic_hold: got %h want fffffffb", dout); end
    exp_do = 32'hFFFF_FFFB;
  endtask

  task automatic test_bypass();
    we = 1'b1; wa = 16'd7; din = 32'h0000_AAAA;
    tick();
    wa = 16'd7; din = 32'h1234_5678; re = 1'b1; ra = 16'd7;
    mdl[7] = 32'h1234_5678;
    tick();
    idle_inputs();
    total++; if (dout !== 32'h1234_5678) begin bad++; $display("FAIL bypass_dout: got %h want 12345678", dout); end
    total++; if (rv !== 1'b1) begin bad++; $display("FAIL bypass_rv: got %b want 1", rv); end
    exp_do = 32'h1234_5678;
  endtask

  task automatic test_addr_error();
    we = 1'b1; wa = 16'd10; din = 32'hDEAD_BEEF;
    tick();
    we = 1'b0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL wr_oor_err: got %b want 1", err); end
    total++; if (rv !== 1'b0) begin bad++; $display("FAIL wr_oor_rv: got %b want 0", rv); end
    tick();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL wr_oor_pulse: got %b want 0", err); end
    re = 1'b1; ra = 16'd12;
    tick();
    re = 1'b0;
    total++; if (dout !== '0) begin bad++; $display("FAIL rd_oor_dout: got %h want 0", dout); end
    total++; if (rv !== 1'b1) begin bad++; $display("FAIL rd_oor_rv: got %b want 1", rv); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL rd_oor_err: got %b want 1", err); end
    we = 1'b1; wa = 16'hFFFF; re = 1'b1; ra = 16'd15;
    tick();
    idle_inputs();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL both_oor_err: got %b want 1", err); end
    tick();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL both_oor_single: got %b want 0", err); end
    exp_do = '0;
    for (int i = 0; i < D; i++) begin
      if (i == 3 || i == 7) begin
        re = 1'b1; ra = AW'(i);
        tick();
        re = 1'b0;
        total++; if (dout !== mdl[i]) begin bad++; $display("FAIL oor_unchanged a=%0d: got %h want %h", i, dout, mdl[i]); end
        exp_do = mdl[i];
      end
    end
  endtask

  task automatic test_random();
    logic          e_rv;
    logic          e_err;
    logic          wr_ok;
    logic          rd_ok;
    fill_random();
    for (int n = 0; n < 400; n++) begin
      we  = 1'($urandom_range(0, 1));
      re  = 1'($urandom_range(0, 1));
      wa  = AW'($urandom_range(0, 13));
      ra  = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 13));
      din = $urandom;
      wr_ok = we && (wa < D);
      rd_ok = re && (ra < D);
      e_rv  = re;
      e_err = (we && !wr_ok) || (re && !rd_ok);
      if (re) begin
        if (!rd_ok) exp_do = '0;
        else if (wr_ok && wa == ra) exp_do = din;
        else exp_do = mdl[ra];
      end
      if (wr_ok) mdl[wa] = din;
      tick();
      total++; if (rv !== e_rv) begin bad++; $display("FAIL rand_rv n=%0d: got %b want %b", n, rv, e_rv); end
      total++; if (err !== e_err) begin bad++; $display("FAIL rand_err n=%0d: got %b want %b", n, err, e_err); end
      total++; if (dout !== exp_do) begin bad++; $display("FAIL rand_dout n=%0d: got %h want %h", n, dout, exp_do); end
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    int busy_cnt;
    fill_random();
    cs = 1'b1;
    tick();
    cs = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL clear_busy_rise: got %b want 1", busy); end
    busy_cnt = 0;
    while (busy === 1'b1 && busy_cnt < 50) begin
      busy_cnt++;
      we = 1'b1; wa = 16'd11; din = 32'h5555_5555;
      re = 1'b1; ra = (busy_cnt % 2 == 1) ? 16'd12 : 16'd2;
      cs = (busy_cnt == 3);
      tick();
      total++; if (rv !== 1'b0) begin bad++; $display("FAIL clear_rv c=%0d: got %b want 0", busy_cnt, rv); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL clear_err c=%0d: got %b want 0", busy_cnt, err); end
    end
    idle_inputs();
    total++; if (busy_cnt != D) begin bad++; $display("FAIL clear_busy_len: got %0d want %0d", busy_cnt, D); end
    total++; if (dout !== exp_do) begin bad++; $display("FAIL clear_dout_hold: got %h want %h", dout, exp_do); end
    for (int i = 0; i < D; i++) mdl[i] = '0;
    for (int i = 0; i < D; i++) begin
      re = 1'b1; ra = AW'(i);
      tick();
      total++; if (dout !== '0 || rv !== 1'b1) begin bad++; $display("FAIL clear_zero a=%0d: got %h/%b want 0/1", i, dout, rv); end
    end
    re = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clear_no_restart: got %b want 0", busy); end
    exp_do = '0;
  endtask

  task automatic test_reset_mid_clear();
    fill_random();
    cs = 1'b1;
    tick();
    cs = 1'b0;
    repeat (4) tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midclr_busy_pre: got %b want 1", busy); end
    #2 reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midclr_busy_async: got %b want 0", busy); end
    total++; if (dout !== '0) begin bad++; $display("FAIL midclr_dout: got %h want 0", dout); end
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    for (int i = 0; i < D; i++) begin
      re = 1'b1; ra = AW'(i);
      tick();
      total++; if (dout !== mdl[i]) begin bad++; $display("FAIL midclr_data a=%0d: got %h want %h", i, dout, mdl[i]); end
    end
    re = 1'b0;
    exp_do = mdl[D-1];
  endtask

`ifdef NN_LAYER_MEMORY_ARGMAX_EN
  task automatic test_argmax();
    logic signed [DW-1:0] vals [4];
    logic [AW-1:0]        addrs [4];
    logic signed [DW-1:0] e_val;
    logic [AW-1:0]        e_idx;
    int                   guard;
    vals[0] = -32'sd3;   addrs[0] = 16'd0;
    vals[1] = 32'sd17;   addrs[1] = 16'd4;
    vals[2] = 32'sd17;   addrs[2] = 16'd6;
    vals[3] = -32'sd100; addrs[3] = 16'd2;
    cs = 1'b1;
    tick();
    cs = 1'b0;
    total++; if (max_valid !== 1'b0) begin bad++; $display("FAIL argmax_clear0: got %b want 0", max_valid); end
    guard = 0;
    while (busy === 1'b1 && guard < 50) begin guard++; tick(); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL argmax_busy_timeout: got %b want 0", busy); end
    e_val = vals[0]; e_idx = addrs[0];
    for (int i = 1; i < 4; i++) if (vals[i] > e_val) begin e_val = vals[i]; e_idx = addrs[i]; end
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; wa = addrs[i]; din = vals[i];
      tick();
    end
    we = 1'b0;
    total++; if (max_value !== e_val) begin bad++; $display("FAIL argmax_value: got %h want %h", max_value, e_val); end
    total++; if (max_index !== e_idx) begin bad++; $display("FAIL argmax_index: got %0d want %0d", max_index, e_idx); end
    total++; if (max_valid !== 1'b1) begin bad++; $display("FAIL argmax_valid: got %b want 1", max_valid); end
    we = 1'b1; wa = 16'd4; din = 32'sd1;
    tick();
    we = 1'b0;
    total++; if (max_value !== e_val) begin bad++; $display("FAIL argmax_no_lower: got %h want %h", max_value, e_val); end
    cs = 1'b1;
    tick();
    cs = 1'b0;
    total++; if (max_valid !== 1'b0) begin bad++; $display("FAIL argmax_after_clear: got %b want 0", max_valid); end
    guard = 0;
    while (busy === 1'b1 && guard < 50) begin guard++; tick(); end
    for (int i = 0; i < D; i++) mdl[i] = '0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_rw();
    test_bypass();
    test_addr_error();
    test_random();
    test_clear();
    test_reset_mid_clear();
`ifdef NN_LAYER_MEMORY_ARGMAX_EN
    test_argmax();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
